// File: rtl/id_exe_if.sv
// id_exe_if: decoded-instruction bundle between the ID stage and the ID/EXE pipeline register.
interface id_exe_if;
    logic        flush;
    logic        freeze;
    logic        valid_in;
    logic [3:0]  exeCmd_in;
    logic        memRead_in;
    logic        memWrite_in;
    logic        wbEn_in;
    logic        branch_in;
    logic        sOut_in;
    logic        move_in;
    logic [31:0] pc_in;
    logic [31:0] valRn_in;
    logic [31:0] valRm_in;
    logic [11:0] shiftOperand_in;
    logic        imm_in;
    logic [23:0] signedImm24_in;
    logic [3:0]  dest_in;
    logic [3:0]  src1_in;
    logic [3:0]  src2_in;
    logic        carry_in;
    logic        valid_out;
    logic [3:0]  exeCmd_out;
    logic        memRead_out;
    logic        memWrite_out;
    logic        wbEn_out;
    logic        branch_out;
    logic        sOut_out;
    logic        move_out;
    logic [31:0] pc_out;
    logic [31:0] valRn_out;
    logic [31:0] valRm_out;
    logic [11:0] shiftOperand_out;
    logic        imm_out;
    logic [23:0] signedImm24_out;
    logic [3:0]  dest_out;
    logic [3:0]  src1_out;
    logic [3:0]  src2_out;
    logic        carry_out;
    logic [15:0] bubble_count;
    modport master (
        output flush, freeze, valid_in, exeCmd_in, memRead_in, memWrite_in, wbEn_in, branch_in,
               sOut_in, move_in, pc_in, valRn_in, valRm_in, shiftOperand_in, imm_in,
               signedImm24_in, dest_in, src1_in, src2_in, carry_in,
        input  valid_out, exeCmd_out, memRead_out, memWrite_out, wbEn_out, branch_out,
               sOut_out, move_out, pc_out, valRn_out, valRm_out, shiftOperand_out, imm_out,
               signedImm24_out, dest_out, src1_out, src2_out, carry_out, bubble_count
    );
    modport slave (
        input  flush, freeze, valid_in, exeCmd_in, memRead_in, memWrite_in, wbEn_in, branch_in,
               sOut_in, move_in, pc_in, valRn_in, valRm_in, shiftOperand_in, imm_in,
               signedImm24_in, dest_in, src1_in, src2_in, carry_in,
        output valid_out, exeCmd_out, memRead_out, memWrite_out, wbEn_out, branch_out,
               sOut_out, move_out, pc_out, valRn_out, valRm_out, shiftOperand_out, imm_out,
               signedImm24_out, dest_out, src1_out, src2_out, carry_out, bubble_count
    );
endinterface

// File: rtl/id_exe_reg.sv
// id_exe_reg: ID/EXE pipeline register with freeze, flush (dominant) and a saturating bubble counter.
module id_exe_reg (
    input logic     clk,
    input logic     rst,
    id_exe_if.slave bus
);
    logic [10:0]  r_ctrl;
    logic [145:0] r_data;
    logic [15:0]  r_bubbles;
    logic [10:0]  w_ctrl;
    logic [145:0] w_data;
    logic         w_bubble;
    // trailing 1 becomes valid_out; gating by valid_in turns an invalid load into a bubble
    assign w_ctrl = {bus.exeCmd_in, bus.memRead_in, bus.memWrite_in, bus.wbEn_in, bus.branch_in,
                     bus.sOut_in, bus.move_in, 1'b1} & {11{bus.valid_in}};
    assign w_data = {bus.pc_in, bus.valRn_in, bus.valRm_in, bus.shiftOperand_in, bus.imm_in,
                     bus.signedImm24_in, bus.dest_in, bus.src1_in, bus.src2_in, bus.carry_in};
    assign w_bubble = bus.flush | (~bus.freeze & ~bus.valid_in);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_data    <= '0;
            r_bubbles <= '0;
        end else begin
            if (w_bubble && !(&r_bubbles))
                r_bubbles <= r_bubbles + 16'd1;
            if (bus.flush) begin
                r_ctrl <= '0;
                r_data <= '0;
            end else if (!bus.freeze) begin
                r_ctrl <= w_ctrl;
                r_data <= w_data;
            end
        end
    end
    assign {bus.exeCmd_out, bus.memRead_out, bus.memWrite_out, bus.wbEn_out, bus.branch_out,
            bus.sOut_out, bus.move_out, bus.valid_out} = r_ctrl;
    assign {bus.pc_out, bus.valRn_out, bus.valRm_out, bus.shiftOperand_out, bus.imm_out,
            bus.signedImm24_out, bus.dest_out, bus.src1_out, bus.src2_out, bus.carry_out} = r_data;
    assign bus.bubble_count = r_bubbles;
endmodule
